// File: rtl/wb_trace_pkg.sv
// Shared types and constants for the writeback trace buffer.
// No logic; no latency.
// No flow control; consumers pick their own backpressure.
package wb_trace_pkg;

    localparam int DATA_W        = 32;
    localparam int OVF_W_DEFAULT = 16;

    typedef logic [DATA_W-1:0] word_t;

endpackage

// File: rtl/wb_trace_mem.sv
// Trace entry storage: DEPTH words, one synchronous write port, one asynchronous read port.
// Write lands on the clock edge; the read port is combinational from raddr.
// No backpressure; the owner guarantees it never writes a live entry.
module wb_trace_mem
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  word_t         wdata,
    input  logic [AW-1:0] raddr,
    output word_t         rdata
);

    // Left unreset on purpose: contents are don't-care until written.
    word_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/wb_trace_buffer.sv
// First-word-fall-through trace FIFO for core writeback beats; optional dedup under WB_TRACE_DEDUP_EN.
// Pushed beat appears on rd_valid/rd_data one cycle after the push edge; no empty bypass.
// Producer cannot be stalled: beats arriving when full with no pop are dropped and counted in ovf_cnt.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int OVF_W = OVF_W_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wb_valid,
    input  logic [DATA_W-1:0]        WB_Data,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [OVF_W-1:0]         ovf_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);
    localparam logic [OVF_W-1:0] OVF_MAX = '1;

    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [OVF_W-1:0] ovf_q;

    logic  beat_vld;
    logic  push;
    logic  pop;
    logic  drop;
    word_t head_dat;

    assign full     = (count_q == DEPTH_C);
    assign empty    = (count_q == '0);
    assign rd_valid = !empty;
    assign rd_data  = head_dat;
    assign count    = count_q;
    assign ovf_cnt  = ovf_q;

    assign pop  = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign push = beat_vld && (!full || pop);
    assign drop = beat_vld && full && !pop;

`ifdef WB_TRACE_DEDUP_EN
    word_t last_q;
    logic  last_vld_q;
    logic  dup;

    assign dup      = last_vld_q && (WB_Data == last_q);
    assign beat_vld = wb_valid && !dup;

    // Only accepted beats update the reference; dropped beats leave it alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_vld_q <= 1'b0;
        end else if (push) begin
            last_vld_q <= 1'b1;
            last_q     <= WB_Data;
        end
    end
`else
    assign beat_vld = wb_valid;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= '0;
        end else begin
            // Pointers are AW bits wide, so power-of-two DEPTH wraps for free.
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (drop && (ovf_q != OVF_MAX)) begin
                ovf_q <= ovf_q + OVF_W'(1);
            end
        end
    end

    wb_trace_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !reset),
        .waddr (wr_ptr_q),
        .wdata (WB_Data),
        .raddr (rd_ptr_q),
        .rdata (head_dat)
    );

endmodule

// File: tb/tb_wb_trace_buffer.sv
// Directed self-checking bench for wb_trace_buffer (DEPTH=8); dedup expectations follow WB_TRACE_DEDUP_EN.
module tb_wb_trace_buffer;

    logic        clk;
    logic        reset;
    logic        wb_valid;
    logic [31:0] WB_Data;
    logic        rd_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic [3:0]  count;
    logic        full;
    logic        empty;
    logic [15:0] ovf_cnt;

    int checks;
    int fails;

    wb_trace_buffer #(
        .DEPTH (8),
        .OVF_W (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .wb_valid (wb_valid),
        .WB_Data  (WB_Data),
        .rd_ready (rd_ready),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .ovf_cnt  (ovf_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; wb_valid = 1'b1; WB_Data = 32'hDEAD; rd_ready = 1'b0;
        step();
        step();
        reset = 1'b0; wb_valid = 1'b0;
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty: got %b want 1", empty); end
        checks++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full: got %b want 0", full); end
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", count); end
        checks++; if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL reset_ovf: got %0d want 0", ovf_cnt); end
    endtask

    task automatic test_first_push();
        wb_valid = 1'b1; WB_Data = 32'h11; rd_ready = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL first_no_bypass: got %b want 0", rd_valid); end
        step();
        wb_valid = 1'b0; WB_Data = 32'hFFFF_FFFF;
        checks++; if (rd_valid !== 1'b1) begin fails++; $display("FAIL first_rd_valid: got %b want 1", rd_valid); end
        checks++; if (rd_data !== 32'h11) begin fails++; $display("FAIL first_rd_data: got %h want 11", rd_data); end
        checks++; if (count !== 4'd1) begin fails++; $display("FAIL first_count: got %0d want 1", count); end
        step();
        checks++; if (count !== 4'd1) begin fails++; $display("FAIL idle_data_ignored: got %0d want 1", count); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL first_drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_empty_read();
        rd_ready = 1'b1;
        step();
        step();
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL empty_read_count: got %0d want 0", count); end
        wb_valid = 1'b1; WB_Data = 32'h99;
        step();
        wb_valid = 1'b0;
        checks++; if (count !== 4'd1) begin fails++; $display("FAIL empty_read_push_count: got %0d want 1", count); end
        checks++; if (rd_data !== 32'h99) begin fails++; $display("FAIL empty_read_push_data: got %h want 99", rd_data); end
        step();
        rd_ready = 1'b0;
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL empty_read_pop_count: got %0d want 0", count); end
    endtask

    task automatic test_fill_overflow();
        rd_ready = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            wb_valid = 1'b1; WB_Data = 32'(i);
            step();
            if (i == 8) begin
                checks++; if (full !== 1'b1) begin fails++; $display("FAIL fill_full: got %b want 1", full); end
                checks++; if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL fill_ovf_before: got %0d want 0", ovf_cnt); end
            end
        end
        wb_valid = 1'b0;
        checks++; if (count !== 4'd8) begin fails++; $display("FAIL fill_count: got %0d want 8", count); end
        checks++; if (ovf_cnt !== 16'd1) begin fails++; $display("FAIL fill_ovf: got %0d want 1", ovf_cnt); end
        rd_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (rd_data !== 32'(i)) begin fails++; $display("FAIL fill_drain_%0d: got %h want %h", i, rd_data, i); end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL fill_drain_empty: got %b want 1", empty); end
    endtask

    task automatic test_full_push_pop();
        logic [31:0] exp_q[$];
        rd_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wb_valid = 1'b1; WB_Data = 32'h21 + 32'(i);
            step();
        end
        wb_valid = 1'b1; WB_Data = 32'hAA; rd_ready = 1'b1;
        step();
        wb_valid = 1'b0; rd_ready = 1'b0;
        checks++; if (count !== 4'd8) begin fails++; $display("FAIL fpp_count: got %0d want 8", count); end
        checks++; if (ovf_cnt !== 16'd1) begin fails++; $display("FAIL fpp_ovf: got %0d want 1", ovf_cnt); end
        for (int i = 1; i < 8; i++) exp_q.push_back(32'h21 + 32'(i));
        exp_q.push_back(32'hAA);
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rd_data !== exp_q[i]) begin fails++; $display("FAIL fpp_drain_%0d: got %h want %h", i, rd_data, exp_q[i]); end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL fpp_empty: got %b want 1", empty); end
    endtask

    task automatic test_wrap_stream();
        logic [31:0] exp_q[$];
        rd_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            wb_valid = 1'b1; WB_Data = 32'h31 + 32'(i);
            exp_q.push_back(32'h31 + 32'(i));
            step();
        end
        for (int i = 0; i < 12; i++) begin
            wb_valid = 1'b1; WB_Data = 32'h40 + 32'(i); rd_ready = 1'b1;
            checks++; if (rd_data !== exp_q[0]) begin fails++; $display("FAIL wrap_out_%0d: got %h want %h", i, rd_data, exp_q[0]); end
            void'(exp_q.pop_front());
            exp_q.push_back(32'h40 + 32'(i));
            step();
            checks++; if (count !== 4'd3) begin fails++; $display("FAIL wrap_count_%0d: got %0d want 3", i, count); end
        end
        wb_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++; if (rd_data !== exp_q[i]) begin fails++; $display("FAIL wrap_tail_%0d: got %h want %h", i, rd_data, exp_q[i]); end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (ovf_cnt !== 16'd1) begin fails++; $display("FAIL wrap_ovf: got %0d want 1", ovf_cnt); end
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL wrap_empty: got %b want 1", empty); end
    endtask

    task automatic test_dedup();
        logic [31:0] beats[4];
        logic [31:0] exp_q[$];
        beats[0] = 32'h5; beats[1] = 32'h5; beats[2] = 32'h6; beats[3] = 32'h5;
`ifdef WB_TRACE_DEDUP_EN
        exp_q.push_back(32'h5); exp_q.push_back(32'h6); exp_q.push_back(32'h5);
`else
        exp_q.push_back(32'h5); exp_q.push_back(32'h5); exp_q.push_back(32'h6); exp_q.push_back(32'h5);
`endif
        rd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wb_valid = 1'b1; WB_Data = beats[i];
            step();
        end
        wb_valid = 1'b0;
        checks++; if (count !== 4'(exp_q.size())) begin fails++; $display("FAIL dedup_count: got %0d want %0d", count, exp_q.size()); end
        checks++; if (ovf_cnt !== 16'd1) begin fails++; $display("FAIL dedup_ovf: got %0d want 1", ovf_cnt); end
        rd_ready = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            checks++; if (rd_data !== exp_q[i]) begin fails++; $display("FAIL dedup_out_%0d: got %h want %h", i, rd_data, exp_q[i]); end
            step();
        end
        rd_ready = 1'b0;
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL dedup_empty: got %b want 1", empty); end
    endtask

    task automatic test_reset_mid_stream();
        rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wb_valid = 1'b1; WB_Data = 32'h61 + 32'(i);
            step();
        end
        checks++; if (count !== 4'd5) begin fails++; $display("FAIL mid_pre_count: got %0d want 5", count); end
        wb_valid = 1'b1; WB_Data = 32'h77; reset = 1'b1;
        step();
        reset = 1'b0; wb_valid = 1'b0;
        checks++; if (count !== 4'd0) begin fails++; $display("FAIL mid_count: got %0d want 0", count); end
        checks++; if (empty !== 1'b1) begin fails++; $display("FAIL mid_empty: got %b want 1", empty); end
        checks++; if (ovf_cnt !== 16'd0) begin fails++; $display("FAIL mid_ovf: got %0d want 0", ovf_cnt); end
        step();
        checks++; if (rd_valid !== 1'b0) begin fails++; $display("FAIL mid_discard: got %b want 0", rd_valid); end
        wb_valid = 1'b1; WB_Data = 32'h77;
        step();
        wb_valid = 1'b0;
        checks++; if (rd_data !== 32'h77) begin fails++; $display("FAIL mid_repush_data: got %h want 77", rd_data); end
        checks++; if (count !== 4'd1) begin fails++; $display("FAIL mid_repush_count: got %0d want 1", count); end
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        reset    = 1'b1;
        wb_valid = 1'b0;
        WB_Data  = 32'h0;
        rd_ready = 1'b0;
        test_reset();
        test_first_push();
        test_empty_read();
        test_fill_overflow();
        test_full_push_pop();
        test_wrap_stream();
        test_dedup();
        test_reset_mid_stream();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/wb_trace_buffer.md
WB_TRACE_BUFFER -- requirements
Module: wb_trace_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning entry count; power of two, minimum 2.
REQ-002 SHALL have parameter OVF_W, default 16, meaning overflow counter width.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port wb_valid  input  1  core writeback beat present this cycle.
REQ-006 SHALL have port WB_Data  input  32  core writeback value; sampled only when wb_valid=1.
REQ-007 SHALL have port rd_ready  input  1  consumer accepts rd_data this cycle.
REQ-008 SHALL have port rd_valid  output  1  head entry available.
REQ-009 SHALL have port rd_data  output  32  head entry value.
REQ-010 SHALL have port count  output  $clog2(DEPTH)+1  entries held.
REQ-011 SHALL have ports full and empty  output  1 each  count==DEPTH and count==0 respectively.
REQ-012 SHALL have port ovf_cnt  output  OVF_W  dropped-beat count.

Function
REQ-013 SHALL implement a first-word-fall-through FIFO: rd_valid = !empty, rd_data = entry at read pointer, both purely registered-state driven.
REQ-014 SHALL push when wb_valid=1 and (full=0 or a pop occurs in the same cycle).
REQ-015 SHALL pop when rd_valid=1 and rd_ready=1.
REQ-016 SHALL make a pushed beat visible on rd_valid/rd_data exactly 1 cycle after the push edge; no same-cycle bypass when empty.
REQ-017 SHALL, on simultaneous push and pop, keep count unchanged, advance both pointers, including when full.
REQ-018 SHALL wrap read and write pointers modulo DEPTH.
REQ-019 SHALL, when wb_valid=1, full=1 and no pop, drop the beat, leave contents unchanged, and increment ovf_cnt by 1.
REQ-020 SHALL saturate ovf_cnt at 2^OVF_W-1; it never wraps.
REQ-021 SHALL ignore rd_ready when empty (no pointer or count change).
REQ-022 SHALL ignore WB_Data whenever wb_valid=0.

Reset
REQ-023 SHALL, while reset=1 at a clock edge, set pointers and count to 0, ovf_cnt to 0; thus rd_valid=0, empty=1, full=0 the following cycle.
REQ-024 SHALL give reset priority over simultaneous push/pop; beats presented during reset are discarded and not counted as overflow.
REQ-025 SHALL not require storage array reset; rd_data is don't-care while rd_valid=0.

Configuration
REQ-026 SHALL, when macro WB_TRACE_DEDUP_EN is defined, suppress a push whose WB_Data equals the last accepted value, using a last-value register plus valid flag cleared by reset; a suppressed beat neither pushes nor increments ovf_cnt, and a dropped beat (REQ-019) does not update the last-value register.
REQ-027 SHALL, when WB_TRACE_DEDUP_EN is undefined, push every qualifying beat and contain no last-value logic.

Structure
REQ-028 SHALL place the data width constant (32), the OVF_W default, and a word typedef in shared package wb_trace_pkg.
REQ-029 SHALL implement storage in one sub-module wb_trace_mem (DEPTH x 32, one write port, one asynchronous read port); pointer, count and overflow logic stay in wb_trace_buffer.

Verification
REQ-030 SHALL cover: reset, then push 0x11 at cycle N with rd_ready=0 -> rd_valid=1, rd_data=0x11 at N+1, count=1.
REQ-031 SHALL cover: push 0x1..0x9 back-to-back, rd_ready=0, DEPTH=8 -> full=1 after 8th, ovf_cnt=1, drain yields 0x1..0x8 in order.
REQ-032 SHALL cover: full FIFO, wb_valid=1 with WB_Data=0xAA and rd_ready=1 same cycle -> count stays 8, ovf_cnt unchanged, 0xAA emerges last.
REQ-033 SHALL cover: 12 push/pop cycles continuous at count=3 -> pointers wrap, output order matches input, no drop.
REQ-034 SHALL cover: WB_TRACE_DEDUP_EN defined, beats 0x5,0x5,0x6,0x5 -> FIFO holds 0x5,0x6,0x5; undefined -> holds all four.
REQ-035 SHALL cover: reset asserted mid-stream with count=5 and wb_valid=1 -> next cycle count=0, empty=1, ovf_cnt=0.
